// File: rtl/register_write_arbiter_if.sv
// Write-port bus between requesters and the register write arbiter.
// Master side issues write requests; slave side drives the bank write port.
interface register_write_arbiter_if #(
    parameter int W      = 4,
    parameter int ADDR_W = 4,
    parameter int N      = 3
);
    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N*W-1:0]      req_data;
    logic                clear_start;
    logic [N-1:0]        grant;
    logic                rf_write_enable;
    logic [ADDR_W-1:0]   rf_addr;
    logic [W-1:0]        rf_data;
    logic                busy;
    logic                clear_done;

    modport master (
        output req, req_addr, req_data, clear_start,
        input  grant, rf_write_enable, rf_addr, rf_data,
        input  busy, clear_done
    );

    modport slave (
        input  req, req_addr, req_data, clear_start,
        output grant, rf_write_enable, rf_addr, rf_data,
        output busy, clear_done
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter for the register bank write port.
// Also sequences a bank-wide clear that writes zero to every address.
module register_write_arbiter #(
    parameter int W      = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int N      = 3
) (
    input logic                      clk,
    input logic                      reset_synchronous,
    register_write_arbiter_if.slave  bus
);
    localparam int PW    = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [PW-1:0]     rr_ptr;

    logic [N-1:0]      grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [W-1:0]      data_q;
    logic              busy_q;
    logic              done_q;

    logic [N-1:0]      eff_req;
    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     scan_idx;
    logic [PW-1:0]     rr_next;
    logic [N-1:0]      win_onehot;
    logic [ADDR_W-1:0] win_addr;
    logic [W-1:0]      win_data;

    // Pick the first eligible requester scanning from rr_ptr; the current
    // grantee is masked so a held request cannot write twice in a row.
    always_comb begin
        eff_req   = bus.req & ~grant_q;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PW'((int'(rr_ptr) + k) % N);
            if (!win_found && eff_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Winner's payload, one-hot grant and the pointer that follows it.
    always_comb begin
        win_onehot = N'(1) << win_idx;
        win_addr   = ADDR_W'(bus.req_addr >> (int'(win_idx) * ADDR_W));
        win_data   = W'(bus.req_data >> (int'(win_idx) * W));
        rr_next    = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        cnt_next   = cnt + 1'b1;
    end

    // Control FSM and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset_synchronous) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            grant_q <= '0;
            done_q  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.clear_start) begin
                        state  <= S_CLEAR;
                        cnt    <= '0;
                        we_q   <= 1'b1;
                        addr_q <= '0;
                        data_q <= '0;
                        busy_q <= 1'b1;
                    end else if (win_found) begin
                        grant_q <= win_onehot;
                        we_q    <= 1'b1;
                        addr_q  <= win_addr;
                        data_q  <= win_data;
                        rr_ptr  <= rr_next;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (cnt < CNT_W'(DEPTH - 1)) begin
                        cnt    <= cnt_next;
                        we_q   <= 1'b1;
                        addr_q <= cnt_next[ADDR_W-1:0];
                        data_q <= '0;
                    end else begin
                        state  <= S_IDLE;
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant           = grant_q;
    assign bus.rf_write_enable = we_q;
    assign bus.rf_addr         = addr_q;
    assign bus.rf_data         = data_q;
    assign bus.busy            = busy_q;
    assign bus.clear_done      = done_q;
endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed testbench for register_write_arbiter.
// Checks reset, single requester, round-robin and clear sequencing.
module tb_register_write_arbiter;
    localparam int W      = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int N      = 3;

    typedef logic [N+1+ADDR_W+W+2-1:0] obs_t;

    localparam logic [ADDR_W-1:0] EA [N] = '{4'd1, 4'd5, 4'd12};
    localparam logic [W-1:0]      ED [N] = '{4'h3, 4'hA, 4'h6};

    logic clk = 1'b0;
    logic reset_synchronous = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    obs_t exp_o;

    register_write_arbiter_if #(.W(W), .ADDR_W(ADDR_W), .N(N)) bus ();

    register_write_arbiter #(
        .W(W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .N(N)
    ) dut (
        .clk(clk),
        .reset_synchronous(reset_synchronous),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {grant, we, addr, data, busy, done}
    function automatic obs_t obs();
        return {bus.grant, bus.rf_write_enable, bus.rf_addr,
                bus.rf_data, bus.busy, bus.clear_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_synchronous = 1'b1;
        bus.req = '0;
        bus.clear_start = 1'b0;
        tick();
        reset_synchronous = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_addr = {EA[2], EA[1], EA[0]};
        bus.req_data = {ED[2], ED[1], ED[0]};
        bus.clear_start = 1'b0;
        bus.req = 3'b111;
        reset_synchronous = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            n_checks++;
            if (obs() !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs edge%0d: got %h want %h",
                         e, obs(), obs_t'(0));
            end
        end
        reset_synchronous = 1'b0;
        tick();
        exp_o = {3'b001, 1'b1, EA[0], ED[0], 2'b00};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h want %h", obs(), exp_o);
        end
        bus.req = '0;
        tick();
        n_checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.grant !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle_after: got we=%b g=%b want 0/000",
                     bus.rf_write_enable, bus.grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 3'b010;
        tick();
        exp_o = {3'b010, 1'b1, EA[1], ED[1], 2'b00};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL single_grant: got %h want %h", obs(), exp_o);
        end
        tick();
        exp_o = {3'b000, 1'b0, EA[1], ED[1], 2'b00};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL single_masked: got %h want %h", obs(), exp_o);
        end
        tick();
        exp_o = {3'b010, 1'b1, EA[1], ED[1], 2'b00};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL single_regrant: got %h want %h", obs(), exp_o);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_o = {3'(1 << (c % 3)), 1'b1, EA[c%3], ED[c%3], 2'b00};
            n_checks++;
            if (obs() !== exp_o) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: got %h want %h", c, obs(), exp_o);
            end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_clear_pending();
        do_reset();
        bus.clear_start = 1'b1;
        bus.req = 3'b001;
        for (int a = 0; a < DEPTH; a++) begin
            tick();
            bus.clear_start = 1'b0;
            exp_o = {3'b000, 1'b1, 4'(a), 4'h0, 2'b10};
            n_checks++;
            if (obs() !== exp_o) begin
                n_fail++;
                $display("FAIL clear_addr%0d: got %h want %h", a, obs(), exp_o);
            end
        end
        tick();
        exp_o = {3'b000, 1'b0, 4'(DEPTH - 1), 4'h0, 2'b01};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL clear_done_pulse: got %h want %h", obs(), exp_o);
        end
        tick();
        exp_o = {3'b001, 1'b1, EA[0], ED[0], 2'b00};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL clear_then_grant: got %h want %h", obs(), exp_o);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        bit seen;
        do_reset();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int e = 0; e < 7; e++) tick();
        n_checks++;
        if (bus.rf_addr !== 4'd7 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_addr7: got addr=%0d busy=%b want 7/1",
                     bus.rf_addr, bus.busy);
        end
        reset_synchronous = 1'b1;
        tick();
        reset_synchronous = 1'b0;
        n_checks++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL midclear_reset: got %h want %h", obs(), obs_t'(0));
        end
        tick();
        n_checks++;
        if (bus.clear_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_no_done: got done=%b busy=%b want 0/0",
                     bus.clear_done, bus.busy);
        end
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        exp_o = {3'b000, 1'b1, 4'd0, 4'h0, 2'b10};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL midclear_restart: got %h want %h", obs(), exp_o);
        end
        seen = 1'b0;
        for (int e = 0; e < 40 && !seen; e++) begin
            tick();
            if (bus.clear_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midclear_complete: got no clear_done want pulse");
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        bus.clear_start = 1'b1;
        for (int e = 0; e < DEPTH; e++) tick();
        exp_o = {3'b000, 1'b1, 4'(DEPTH - 1), 4'h0, 2'b10};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL retrig_last_write: got %h want %h", obs(), exp_o);
        end
        tick();
        exp_o = {3'b000, 1'b0, 4'(DEPTH - 1), 4'h0, 2'b01};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL retrig_done: got %h want %h", obs(), exp_o);
        end
        tick();
        exp_o = {3'b000, 1'b1, 4'd0, 4'h0, 2'b10};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL retrig_restart: got %h want %h", obs(), exp_o);
        end
        tick();
        exp_o = {3'b000, 1'b1, 4'd1, 4'h0, 2'b10};
        n_checks++;
        if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL retrig_second: got %h want %h", obs(), exp_o);
        end
        bus.clear_start = 1'b0;
        do_reset();
    endtask

    initial begin
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.clear_start = 1'b0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_clear_pending();
        test_reset_mid_clear();
        test_retrigger();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares the single write port of a register bank between N requesters (writeback, load, debug) using round-robin arbitration.
- Also sequences a bank-wide clear: it walks every address and writes zero.
- Drives the register bank's write_enable/address/data inputs and sits between pipeline stages and the bank.
- All outputs are registered.

Parameters:
- W, 4, data width of each register.
- ADDR_W, 4, register address width.
- DEPTH, 16, number of registers cleared by the clear sequence (≤ 2^ADDR_W).
- N, 3, number of requesters (≥ 2).

Ports:
- clk  in  1  system clock; all logic acts on the rising edge.
- reset_synchronous  in  1  synchronous reset, active-high; takes effect at the next rising edge.
- req  in  N  bit i = requester i has a pending write.
- req_addr  in  N*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W].
- req_data  in  N*W  requester i data at bits [i*W +: W].
- clear_start  in  1  request to clear the bank.
- grant  out  N  one-hot; high for one cycle when requester i's write is issued.
- rf_write_enable  out  1  write enable to the register bank.
- rf_addr  out  ADDR_W  write address.
- rf_data  out  W  write data.
- busy  out  1  high while the clear sequence runs.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset:
  - reset_synchronous=1 at an edge: state=IDLE, rr_ptr=0, clear counter=0.
  - After that edge, all outputs are 0 (grant, rf_write_enable, rf_addr, rf_data, busy, clear_done).
  - Reset overrides everything, including mid-clear; an aborted clear does not pulse clear_done.
- States: IDLE, CLEAR.
- Masking: eff_req = req & ~grant. A requester's req is ignored at the edge ending its own grant cycle, so a single request never double-writes.
- Requester contract:
  - Hold req/addr/data stable until grant is observed.
  - May drop req or present the next write during the grant cycle.
- IDLE, edge with clear_start=1:
  - Next state CLEAR, counter=0.
  - Outputs after the edge: rf_write_enable=1, rf_addr=0, rf_data=0, busy=1, grant=0.
  - clear_start beats any pending req in the same cycle.
- IDLE, edge with clear_start=0 and eff_req≠0:
  - Winner = first set bit of eff_req scanning rr_ptr, rr_ptr+1, … modulo N.
  - Outputs after the edge: grant=one-hot(winner), rf_write_enable=1, rf_addr/rf_data = winner's slice.
  - rr_ptr <= (winner+1) mod N.
  - Latency from req to issue: 1 cycle.
- IDLE, edge with eff_req=0:
  - rf_write_enable=0, grant=0.
  - rf_addr/rf_data hold their previous values.
  - rr_ptr unchanged.
- CLEAR, each edge:
  - If counter < DEPTH-1: counter+1, rf_addr=counter+1, rf_data=0, rf_write_enable=1.
  - If counter == DEPTH-1: next state IDLE, rf_write_enable=0, busy=0, clear_done=1 for exactly one cycle.
  - Writes are issued on DEPTH consecutive cycles (addresses 0..DEPTH-1).
- During CLEAR:
  - grant stays 0; req is ignored but stays pending.
  - clear_start is ignored.
  - No grant at the exit edge; arbitration resumes at the first edge sampled in IDLE.
- Fairness and limits:
  - With all N requesting continuously, grants rotate 0,1,…,N-1,0.
  - A single requester gets at most one write every 2 cycles.
- Arithmetic: counter is ADDR_W+1 bits; rr_ptr wraps N-1 → 0 with no overflow artefacts.

Test Plan (W=4, ADDR_W=4, DEPTH=16, N=3):
- Reset: assert reset_synchronous for 2 edges while req=3'b111 -> all outputs 0; first grant after release is requester 0.
- Single requester: req=3'b010, addr1=5, data1=0xA, held -> grant=3'b010 and rf_write_enable=1 / rf_addr=5 / rf_data=0xA one cycle later; then one idle cycle; then a regrant on the alternate cycle.
- Round-robin: req=3'b111 held for 6 cycles -> grant sequence 001, 010, 100, 001, 010, 100 with rf_write_enable high every cycle and matching addr/data.
- Clear with pending request:
  - Stimulus: clear_start pulse with req=3'b001 in the same cycle.
  - Required: busy=1 for 16 cycles; rf_addr 0..15 with rf_data=0; no grant.
  - Required: clear_done pulses 1 cycle with rf_write_enable=0.
  - Required: requester 0 is granted at the edge after clear_done.
- Reset mid-clear: reset_synchronous at the edge where rf_addr=7 -> next cycle busy=0, rf_write_enable=0, no clear_done; a new clear_start restarts at addr 0.
- Clear retrigger: clear_start held high for the whole clear -> after clear_done, IDLE samples clear_start=1 and a new 16-write sequence starts.
